variable_node_update: RTL and testbench

VARIABLE_NODE_UPDATE -- requirements
Module: variable_node_update

---
 rtl/variable_node_update.sv | 200 ++++++++++++++++++++
 tb/tb_variable_node_update.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/variable_node_update.sv
// Variable-node update for an LDPC min-sum/BP decoder column.
// Captures one column's operands, then reuses a single IEEE-754 single
// add/sub unit over four sequential states: total = llr + col_sum, then
// qk = total - rk for k = 1..3. Arithmetic flushes denormals, truncates
// after a 3-guard-bit alignment and saturates instead of producing Inf/NaN.
module variable_node_update (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] col_sum,
  input  logic [31:0] llr,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  output logic [31:0] total_out,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic        hard_bit,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TOTAL = 3'd1,
    EXT1  = 3'd2,
    EXT2  = 3'd3,
    EXT3  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;

  // Operands captured on the accepting edge, held for the whole column.
  logic [31:0] llr_p0, col_sum_p0, r1_p0, r2_p0, r3_p0;

  // Shared adder operands and result.
  logic [31:0] op_a, op_b, add_res;

  // Map special encodings onto the finite range the adder understands:
  // exponent 0 becomes a (signed) zero, exponent 255 becomes max finite.
  function automatic logic [31:0] fp_sanitize(input logic [31:0] w);
    logic [31:0] res;
    res = w;
    if (w[30:23] == 8'd0)
      res = {w[31], 31'd0};
    else if (w[30:23] == 8'hFF)
      res = {w[31], 31'h7F7F_FFFF};
    return res;
  endfunction

  // Truncate a normalised 27-bit significand (hidden bit at [26], three
  // guard bits at [2:0]) and saturate the exponent: underflow gives +0,
  // overflow gives max finite with the result sign.
  function automatic logic [31:0] fp_pack(input logic              sign,
                                          input logic signed [9:0] exp,
                                          input logic [26:0]       norm);
    logic [31:0] res;
    if (exp <= 10'sd0)
      res = 32'd0;
    else if (exp >= 10'sd255)
      res = {sign, 31'h7F7F_FFFF};
    else
      res = {sign, exp[7:0], norm[25:3]};
    return res;
  endfunction

  // Single-precision add. The larger-magnitude operand sets the result sign
  // and reference exponent; the smaller one is shifted right with no sticky
  // bit, so low-order bits are simply dropped. Any zero result is +0.
  function automatic logic [31:0] fp_add(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0]       sa, sb, x, y, res;
    logic [26:0]       mx, my, ms;
    logic [7:0]        d;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] er;
    sa = fp_sanitize(a);
    sb = fp_sanitize(b);
    if (sb[30:0] > sa[30:0]) begin
      x = sb;
      y = sa;
    end else begin
      x = sa;
      y = sb;
    end
    mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    ms = (d >= 8'd27) ? 27'd0 : (my >> d);
    if (x[31] == y[31])
      sum = {1'b0, mx} + {1'b0, ms};
    else
      sum = {1'b0, mx} - {1'b0, ms};
    // Left-normalisation distance: position of the leading one below bit 26.
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    er = $signed({2'b00, x[30:23]});
    if (sum == 28'd0)
      res = 32'd0;
    else if (sum[27])
      res = fp_pack(x[31], er + 10'sd1, sum[27:1]);
    else
      res = fp_pack(x[31], er - $signed({5'b00000, lz}), sum[26:0] << lz);
    return res;
  endfunction

  // State register; clr aborts any column in flight.
  always_ff @(posedge clk) begin
    if (clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state, shared-adder operand steering and status outputs.
  always_comb begin
    state_nxt = state;
    op_a      = total_out;
    op_b      = 32'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = TOTAL;
      end
      TOTAL: begin
        state_nxt = EXT1;
        op_a      = llr_p0;
        op_b      = col_sum_p0;
      end
      EXT1: begin
        state_nxt = EXT2;
        op_b      = {~r1_p0[31], r1_p0[30:0]};
      end
      EXT2: begin
        state_nxt = EXT3;
        op_b      = {~r2_p0[31], r2_p0[30:0]};
      end
      EXT3: begin
        state_nxt = DONE;
        op_b      = {~r3_p0[31], r3_p0[30:0]};
      end
      DONE: begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign add_res = fp_add(op_a, op_b);

  // Stage p0: operand capture on the accepting edge only.
  always_ff @(posedge clk) begin
    if (clr) begin
      llr_p0     <= 32'd0;
      col_sum_p0 <= 32'd0;
      r1_p0      <= 32'd0;
      r2_p0      <= 32'd0;
      r3_p0      <= 32'd0;
    end else if (state == IDLE && start) begin
      llr_p0     <= llr;
      col_sum_p0 <= col_sum;
      r1_p0      <= r1;
      r2_p0      <= r2;
      r3_p0      <= r3;
    end
  end

  // Result registers: each one is written on the edge leaving its state
  // and otherwise holds the previous column's value.
  always_ff @(posedge clk) begin
    if (clr) begin
      total_out <= 32'd0;
      hard_bit  <= 1'b0;
      q1        <= 32'd0;
      q2        <= 32'd0;
      q3        <= 32'd0;
    end else begin
      case (state)
        TOTAL: begin
          total_out <= add_res;
          hard_bit  <= add_res[31];
        end
        EXT1:    q1 <= add_res;
        EXT2:    q2 <= add_res;
        EXT3:    q3 <= add_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_variable_node_update.sv
// Bench for variable_node_update: directed columns from the requirement
// examples plus randomised columns compared against an arithmetic model.
module tb_variable_node_update;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] col_sum, llr, r1, r2, r3;
  logic [31:0] total_out, q1, q2, q3;
  logic        hard_bit, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  variable_node_update dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .col_sum  (col_sum),
    .llr      (llr),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .total_out(total_out),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .hard_bit (hard_bit),
    .busy     (busy),
    .done     (done)
  );

  // Value of a word as (sign, exponent, integer significand * 8).
  function automatic void decode(input logic [31:0] w, output logic s,
                                 output int e, output longint m);
    s = w[31];
    e = int'(w[30:23]);
    if (e == 0) begin
      m = 0;
    end else if (e == 255) begin
      e = 254;
      m = longint'(16777215) * 8;
    end else begin
      m = (longint'(8388608) + longint'(w[22:0])) * 8;
    end
  endfunction

  // Reference add: align the smaller value by integer division (drops the
  // remainder), add as signed integers, renormalise, then apply limits.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic   sa, sb, ts, neg;
    int     ea, eb, te, diff, e;
    longint ma, mb, tm, v, mag;
    decode(a, sa, ea, ma);
    decode(b, sb, eb, mb);
    if (eb > ea || (eb == ea && mb > ma)) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    diff = ea - eb;
    if (diff >= 40) mb = 0;
    else mb = mb / (longint'(1) << diff);
    v = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (v == 0) return 32'h0;
    neg = (v < 0);
    mag = neg ? -v : v;
    e   = ea;
    while (mag >= 134217728) begin mag = mag / 2; e++; end
    while (mag < 67108864)   begin mag = mag * 2; e--; end
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {neg, 31'h7F7F_FFFF};
    return {neg, 8'(e), 23'((mag / 8) % 8388608)};
  endfunction

  function automatic logic [31:0] negate(input logic [31:0] w);
    return {~w[31], w[30:0]};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 7))
      0:       w[30:23] = 8'd0;
      1:       w[30:23] = 8'hFF;
      2:       w[30:23] = 8'($urandom_range(250, 254));
      3:       ;
      default: w[30:23] = 8'($urandom_range(118, 134));
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] t, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input logic h);
    chk({tag, "_total"}, total_out, t);
    chk({tag, "_q1"}, q1, e1);
    chk({tag, "_q2"}, q2, e2);
    chk({tag, "_q3"}, q3, e3);
    chk({tag, "_hard"}, {31'd0, hard_bit}, {31'd0, h});
  endtask

  // One column with latency checks; inputs are scrambled after acceptance.
  task automatic run_column(input string tag, input logic [31:0] a, input logic [31:0] cs,
                            input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] t, e1, e2, e3;
    t  = model_add(a, cs);
    e1 = model_add(t, negate(c1));
    e2 = model_add(t, negate(c2));
    e3 = model_add(t, negate(c3));
    llr = a; col_sum = cs; r1 = c1; r2 = c2; r3 = c3;
    start = 1'b1;
    tick();
    start = 1'b0;
    llr = $urandom(); col_sum = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
    chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    tick(); tick(); tick();
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk_outputs(tag, t, e1, e2, e3, t[31]);
  endtask

  initial begin
    int ndone, first, second;
    logic [31:0] a, cs;
    clr = 1'b1; start = 1'b0;
    llr = 32'd0; col_sum = 32'd0; r1 = 32'd0; r2 = 32'd0; r3 = 32'd0;
    tick(); tick();
    chk_outputs("reset", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("reset_status", {30'd0, busy, done}, 32'd0);
    clr = 1'b0;

    // Basic column, also against the literal expected words.
    run_column("basic", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 32'hBF80_0000);
    chk_outputs("basic_lit", 32'h4040_0000, 32'h4020_0000, 32'h0000_0000, 32'h4080_0000, 1'b0);

    run_column("negtot", 32'hC080_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
    chk_outputs("negtot_lit", 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 1'b1);

    run_column("denorm", 32'h0000_0001, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
    chk("denorm_lit", total_out, 32'h3F80_0000);
    run_column("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0, 32'h0, 32'h0);
    chk("ovf_lit", total_out, 32'h7F7F_FFFF);
    run_column("cancel", 32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'h0, 32'h0);
    chk("cancel_lit", {total_out, 31'd0, hard_bit} == {32'h0, 32'h0} ? 32'd1 : 32'd0, 32'd1);

    // Randomised columns, some forced into exact cancellation.
    for (int i = 0; i < 24; i++) begin
      a  = rnd_word();
      cs = (i % 5 == 0) ? negate(a) : rnd_word();
      run_column("rand", a, cs, rnd_word(), rnd_word(), rnd_word());
    end

    // Start pulsed again in EXT2 must be ignored.
    llr = 32'h3F80_0000; col_sum = 32'h4000_0000; r1 = 32'h3F00_0000; r2 = 32'h4040_0000; r3 = 32'hBF80_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    llr = 32'hC080_0000; col_sum = 32'h3F80_0000; r1 = 32'h0; r2 = 32'h0; r3 = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
      if (i == 1) chk("busystart_busy", {31'd0, busy}, 32'd0);
    end
    chk("busystart_ndone", 32'(ndone), 32'd1);
    chk_outputs("busystart", 32'h4040_0000, 32'h4020_0000, 32'h0000_0000, 32'h4080_0000, 1'b0);

    // Reset during EXT1 aborts with no done pulse.
    llr = 32'hC080_0000; col_sum = 32'h3F80_0000; r1 = 32'h0; r2 = 32'h0; r3 = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_outputs("abort", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("abort_status", {30'd0, busy, done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    run_column("after_abort", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 32'hBF80_0000);
    chk_outputs("after_abort_lit", 32'h4040_0000, 32'h4020_0000, 32'h0000_0000, 32'h4080_0000, 1'b0);

    // Start on the very first edge after clr deasserts.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    run_column("post_clr", 32'hC080_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);

    // Back-to-back columns with start held high.
    llr = 32'h3F80_0000; col_sum = 32'h4000_0000; r1 = 32'h3F00_0000; r2 = 32'h4040_0000; r3 = 32'hBF80_0000;
    start = 1'b1;
    ndone = 0; first = -1; second = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin
        llr = 32'hC080_0000; col_sum = 32'h3F80_0000; r1 = 32'h0; r2 = 32'h0; r3 = 32'h0;
      end
      if (i == 12) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first = i;
          chk_outputs("b2b_first", 32'h4040_0000, 32'h4020_0000, 32'h0000_0000, 32'h4080_0000, 1'b0);
        end else if (ndone == 2) begin
          second = i;
          chk_outputs("b2b_second", 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 1'b1);
        end
      end
    end
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_first_at", 32'(first), 32'd5);
    chk("b2b_gap", 32'(second - first), 32'd6);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
